// File: rtl/lsu.sv
// Load/store unit: turns an ALU effective address into one byte/half/word
// access on a req/gnt/rvalid data bus, rejecting misaligned or illegal sizes.
module lsu #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_i,
   input  logic            we_i,
   input  logic [1:0]      size_i,
   input  logic            unsigned_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            err_o,
   output logic [XLEN-1:0] rdata_o,
   output logic            data_req_o,
   input  logic            data_gnt_i,
   output logic [XLEN-1:0] data_addr_o,
   output logic            data_we_o,
   output logic [3:0]      data_be_o,
   output logic [XLEN-1:0] data_wdata_o,
   input  logic            data_rvalid_i,
   input  logic [XLEN-1:0] data_rdata_i
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, RESP} state_t;

   state_t          state;
   logic [1:0]      lat_size;
   logic            lat_uns;
   logic [1:0]      lat_off;

   logic            bad;
   logic [3:0]      be;
   logic [XLEN-1:0] wdata_rep;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] ext;

   always_comb begin
      bad       = 1'b0;
      be        = 4'b1111;
      wdata_rep = wdata_i;
      case (size_i)
         2'd0: begin
            be        = 4'b0001 << addr_i[1:0];
            wdata_rep = {4{wdata_i[7:0]}};
         end
         2'd1: begin
            bad       = addr_i[0];
            be        = 4'b0011 << addr_i[1:0];
            wdata_rep = {2{wdata_i[15:0]}};
         end
         2'd2:    bad = (addr_i[1:0] != 2'b00);
         default: bad = 1'b1;
      endcase
   end

   // Extraction uses the latched size/offset since addr_i may change mid-access.
   always_comb begin
      shifted = data_rdata_i >> {lat_off, 3'b000};
      case (lat_size)
         2'd0:    ext = lat_uns ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         2'd1:    ext = lat_uns ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         default: ext = data_rdata_i;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
         rdata_o      <= '0;
         data_req_o   <= 1'b0;
         data_addr_o  <= '0;
         data_we_o    <= 1'b0;
         data_be_o    <= '0;
         data_wdata_o <= '0;
         lat_size     <= '0;
         lat_uns      <= 1'b0;
         lat_off      <= '0;
      end else begin
         case (state)
            IDLE: begin
               done_o <= 1'b0;
               err_o  <= 1'b0;
               if (req_i) begin
                  if (bad) begin
                     state  <= RESP;
                     done_o <= 1'b1;
                     err_o  <= 1'b1;
                  end else begin
                     state        <= REQ;
                     busy_o       <= 1'b1;
                     data_req_o   <= 1'b1;
                     data_addr_o  <= {addr_i[XLEN-1:2], 2'b00};
                     data_we_o    <= we_i;
                     data_be_o    <= be;
                     data_wdata_o <= wdata_rep;
                     lat_size     <= size_i;
                     lat_uns      <= unsigned_i;
                     lat_off      <= addr_i[1:0];
                  end
               end
            end
            REQ: begin
               if (data_gnt_i) begin
                  data_req_o <= 1'b0;
                  if (data_we_o) begin
                     state  <= RESP;
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                  end else begin
                     state <= WAIT_RD;
                  end
               end
            end
            WAIT_RD: begin
               if (data_rvalid_i) begin
                  rdata_o <= ext;
                  state   <= RESP;
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
               end
            end
            default: begin
               done_o <= 1'b0;
               err_o  <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: scripted bus handshakes with a completion
// scoreboard popped on every done_o pulse.
module tb_lsu;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i, we_i, unsigned_i;
   logic [1:0]  size_i;
   logic [31:0] addr_i, wdata_i;
   logic        busy_o, done_o, err_o;
   logic [31:0] rdata_o;
   logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
   logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
   logic [3:0]  data_be_o;

   typedef struct {
      logic        err;
      logic        ld;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [31:0] last_rdata = '0;

   lsu #(.XLEN(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
      .size_i(size_i), .unsigned_i(unsigned_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .rdata_o(rdata_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
      .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
      .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i),
      .data_rdata_i(data_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   always @(negedge clk_i) begin
      if (done_o === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_err", {31'd0, err_o}, {31'd0, e.err});
            if (e.ld) check("sb_rdata", rdata_o, e.data);
         end
      end
   end

   task automatic cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic e_err, input logic e_ld, input logic [31:0] e_data);
      exp_t e;
      e.err = e_err; e.ld = e_ld; e.data = e_data;
      sb.push_back(e);
      req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns;
      addr_i = addr; wdata_i = wd;
      cycle();
      req_i = 1'b0; addr_i = 32'hFFFF_FFFF; wdata_i = '0;
   endtask

   task automatic do_store(input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input int unsigned gnt_wait,
                           input logic [3:0] e_be, input logic [31:0] e_wd);
      issue(1'b1, size, 1'b0, addr, wd, 1'b0, 1'b0, '0);
      for (int unsigned i = 0; i < gnt_wait; i++) begin
         check("st_req_held", {31'd0, data_req_o}, 32'd1);
         check("st_be_held", {28'd0, data_be_o}, {28'd0, e_be});
         cycle();
      end
      data_gnt_i = 1'b1;
      check("st_req", {31'd0, data_req_o}, 32'd1);
      check("st_addr", data_addr_o, addr & 32'hFFFF_FFFC);
      check("st_we", {31'd0, data_we_o}, 32'd1);
      check("st_be", {28'd0, data_be_o}, {28'd0, e_be});
      check("st_wdata", data_wdata_o, e_wd);
      check("st_busy", {31'd0, busy_o}, 32'd1);
      cycle();
      data_gnt_i = 1'b0;
      check("st_done", {31'd0, done_o}, 32'd1);
      check("st_req_drop", {31'd0, data_req_o}, 32'd0);
      check("st_busy_resp", {31'd0, busy_o}, 32'd0);
      cycle();
      check("st_done_once", {31'd0, done_o}, 32'd0);
   endtask

   task automatic do_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                          input logic [31:0] rd, input int unsigned gnt_wait,
                          input int unsigned rv_wait, input logic [3:0] e_be,
                          input logic [31:0] e_data);
      issue(1'b0, size, uns, addr, '0, 1'b0, 1'b1, e_data);
      for (int unsigned i = 0; i < gnt_wait; i++) begin
         check("ld_req_held", {31'd0, data_req_o}, 32'd1);
         check("ld_addr_held", data_addr_o, addr & 32'hFFFF_FFFC);
         check("ld_be_held", {28'd0, data_be_o}, {28'd0, e_be});
         cycle();
      end
      data_gnt_i = 1'b1;
      check("ld_req", {31'd0, data_req_o}, 32'd1);
      check("ld_we", {31'd0, data_we_o}, 32'd0);
      check("ld_be", {28'd0, data_be_o}, {28'd0, e_be});
      cycle();
      data_gnt_i = 1'b0;
      check("ld_req_drop", {31'd0, data_req_o}, 32'd0);
      for (int unsigned i = 0; i < rv_wait; i++) begin
         check("ld_wait_busy", {31'd0, busy_o}, 32'd1);
         check("ld_wait_nodone", {31'd0, done_o}, 32'd0);
         cycle();
      end
      data_rvalid_i = 1'b1; data_rdata_i = rd;
      cycle();
      data_rvalid_i = 1'b0; data_rdata_i = 32'h5A5A_5A5A;
      check("ld_done", {31'd0, done_o}, 32'd1);
      check("ld_rdata", rdata_o, e_data);
      check("ld_busy_resp", {31'd0, busy_o}, 32'd0);
      last_rdata = e_data;
      cycle();
      check("ld_done_once", {31'd0, done_o}, 32'd0);
   endtask

   task automatic do_bad(input logic [1:0] size, input logic [31:0] addr);
      issue(1'b0, size, 1'b0, addr, '0, 1'b1, 1'b0, '0);
      check("bad_done", {31'd0, done_o}, 32'd1);
      check("bad_err", {31'd0, err_o}, 32'd1);
      check("bad_noreq", {31'd0, data_req_o}, 32'd0);
      check("bad_rdata_kept", rdata_o, last_rdata);
      cycle();
      check("bad_noreq2", {31'd0, data_req_o}, 32'd0);
      check("bad_err_clr", {31'd0, err_o}, 32'd0);
   endtask

   initial begin
      rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = '0; unsigned_i = 1'b0;
      addr_i = '0; wdata_i = '0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
      data_rdata_i = '0;
      cycle(); cycle();
      rst_i = 1'b0;
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_done", {31'd0, done_o}, 32'd0);
      check("rst_err", {31'd0, err_o}, 32'd0);
      check("rst_req", {31'd0, data_req_o}, 32'd0);
      check("rst_be", {28'd0, data_be_o}, 32'd0);
      check("rst_rdata", rdata_o, 32'd0);
      check("rst_addr", data_addr_o, 32'd0);
      check("rst_wdata", data_wdata_o, 32'd0);

      do_store(2'd2, 32'h0000_1008, 32'hDEAD_BEEF, 0, 4'b1111, 32'hDEAD_BEEF);
      do_store(2'd0, 32'h0000_1003, 32'h0000_00A5, 0, 4'b1000, 32'hA5A5_A5A5);
      do_store(2'd1, 32'h0000_1002, 32'h1234_5678, 2, 4'b1100, 32'h5678_5678);

      do_load(2'd0, 1'b0, 32'h0000_2001, 32'h1234_80FF, 0, 0, 4'b0010, 32'hFFFF_FF80);
      do_load(2'd0, 1'b1, 32'h0000_2001, 32'h1234_80FF, 0, 0, 4'b0010, 32'h0000_0080);
      do_load(2'd1, 1'b0, 32'h0000_2002, 32'h8001_0000, 3, 2, 4'b1100, 32'hFFFF_8001);
      do_load(2'd1, 1'b1, 32'h0000_2000, 32'h0000_9ABC, 0, 1, 4'b0011, 32'h0000_9ABC);
      do_load(2'd0, 1'b0, 32'h0000_2003, 32'h7F00_0000, 0, 0, 4'b1000, 32'h0000_007F);

      do_bad(2'd2, 32'h0000_2002);
      do_bad(2'd1, 32'h0000_2001);
      do_bad(2'd3, 32'h0000_2000);

      // Reset while waiting for read data; the late rvalid must be ignored.
      issue(1'b0, 2'd2, 1'b0, 32'h0000_3000, '0, 1'b0, 1'b1, '0);
      data_gnt_i = 1'b1;
      cycle();
      data_gnt_i = 1'b0;
      rst_i = 1'b1;
      cycle();
      rst_i = 1'b0;
      sb.delete();
      data_rvalid_i = 1'b1; data_rdata_i = 32'h1111_2222;
      cycle();
      data_rvalid_i = 1'b0;
      check("rr_nodone", {31'd0, done_o}, 32'd0);
      check("rr_rdata", rdata_o, 32'd0);
      check("rr_busy", {31'd0, busy_o}, 32'd0);
      check("rr_req", {31'd0, data_req_o}, 32'd0);
      cycle();
      check("rr_nodone2", {31'd0, done_o}, 32'd0);
      last_rdata = '0;
      do_load(2'd2, 1'b0, 32'h0000_3004, 32'hCAFE_F00D, 0, 0, 4'b1111, 32'hCAFE_F00D);

      cycle(); cycle();
      check("sb_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit sitting directly downstream of the ALU in the execute stage.
- Takes the ALU sum (`out_o`, base+offset) as the effective address and performs one byte, half or word access on the data-memory bus.
- Bus is a req/gnt/rvalid handshake.
- Returns sign- or zero-extended load data to writeback, and flags misaligned or illegal accesses instead of issuing them.

Parameters:
- XLEN, 32, datapath/address width; only 32 is supported (4 byte lanes).

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- req_i  in  1  start access; sampled only when busy_o=0
- we_i  in  1  1=store, 0=load
- size_i  in  2  0=byte, 1=half, 2=word, 3=illegal
- unsigned_i  in  1  loads: 1=zero-extend, 0=sign-extend
- addr_i  in  XLEN  effective address from ALU out_o
- wdata_i  in  XLEN  store data (rs2)
- busy_o  out  1  access in progress; req_i ignored
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  pulses with done_o on a misaligned or illegal access
- rdata_o  out  XLEN  extended load result; valid when done_o=1 and load
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_addr_o  out  XLEN  word-aligned address {addr[31:2],2'b00}
- data_we_o  out  1  bus write enable
- data_be_o  out  4  byte enables
- data_wdata_o  out  XLEN  lane-replicated store data
- data_rvalid_i  in  1  read data valid
- data_rdata_i  in  XLEN  read data

Behaviour:
- FSM states: IDLE, REQ, WAIT_RD, RESP.
- Reset (rst_i=1 at an edge):
  - State goes to IDLE.
  - busy_o, done_o, err_o, data_req_o, data_we_o = 0.
  - data_be_o = 0; rdata_o, data_addr_o, data_wdata_o = 0.
  - Reset mid-access abandons the access; data_req_o is 0 from the next cycle; any later rvalid_i is ignored.
- IDLE with req_i=1, access is bad:
  - Bad means: size 3, half with addr[0]=1, or word with addr[1:0]≠0.
  - Go to RESP with err_o=1. No bus request is made and rdata_o is unchanged.
- IDLE with req_i=1, access is good:
  - Latch addr, we, size, unsigned and wdata.
  - Go to REQ; busy_o=1 from the next cycle.
- REQ:
  - data_req_o=1; addr, we, be and wdata are driven from latched values.
  - These signals stay stable until data_gnt_i=1.
  - On gnt: a store goes to RESP; a load goes to WAIT_RD. data_req_o drops the cycle after gnt.
- WAIT_RD:
  - On data_rvalid_i=1, register the extracted load value into rdata_o and go to RESP.
  - rvalid_i is ignored in every other state.
- RESP:
  - done_o=1 for exactly one cycle; err_o=1 only for a bad access.
  - busy_o=0 in RESP. Next state is IDLE.
  - req_i in RESP is ignored; the next request is accepted in IDLE.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0] (addr[1:0] is 0 or 2)
  - word: 4'b1111
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction:
  - Shift: shifted = data_rdata_i >> (8*addr[1:0]).
  - byte: shifted[7:0], extended to XLEN.
  - half: shifted[15:0], extended to XLEN.
  - word: data_rdata_i as is.
- Latency with zero bus wait states (req_i sampled at edge 0):
  - Store: data_req_o in cycle 1, done_o in cycle 2.
  - Load: rvalid in cycle 2, done_o and rdata_o in cycle 3.
  - Bad access: done_o and err_o in cycle 1.
- Stalls: gnt low for N cycles extends REQ by N cycles with outputs held; rvalid delay extends WAIT_RD.

Test Plan:
1. Aligned word store, addr=0x0000_1008, wdata=0xDEADBEEF, gnt same cycle as req -> data_addr_o=0x1008, be=4'b1111, data_we_o=1, done_o 2 cycles after req_i, err_o=0.
2. Byte store, addr=0x0000_1003, wdata=0x0000_00A5 -> be=4'b1000, data_wdata_o=0xA5A5A5A5.
3. Byte load, addr=0x2001, data_rdata_i=0x1234_80FF:
   - with unsigned_i=0 -> rdata_o=0xFFFF_FF80
   - repeated with unsigned_i=1 -> rdata_o=0x0000_0080
4. Half load, addr=0x2002, data_rdata_i=0x8001_0000, unsigned_i=0, gnt held low 3 cycles, rvalid 2 cycles after gnt -> req/addr/be=4'b1100 stable throughout, rdata_o=0xFFFF_8001, single done_o pulse, busy_o high until RESP.
5. Misaligned and illegal accesses:
   - word addr=0x2002 -> done_o=err_o=1 one cycle later, data_req_o never asserted
   - half addr=0x2001 -> same response
   - size_i=3 -> same response
6. Reset during WAIT_RD, then rvalid_i pulsed the following cycle -> no done_o, rdata_o=0, FSM IDLE. A new word load then completes normally.
